// File: rtl/hack_pkg.sv
// Shared constants for the Hack control unit: FSM encodings and instruction field positions.
// No logic here; imported by every hack_* file.
package hack_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEMRD  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEMWR  = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_RESET  = ST_FETCH;

  localparam int unsigned BIT_TYPE   = 15;
  localparam int unsigned BIT_A      = 12;
  localparam int unsigned COMP_HI    = 11;
  localparam int unsigned COMP_LO    = 6;
  localparam int unsigned BIT_DEST_A = 5;
  localparam int unsigned BIT_DEST_D = 4;
  localparam int unsigned BIT_DEST_M = 3;
  localparam int unsigned JMP_HI     = 2;
  localparam int unsigned JMP_LO     = 0;

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition from the C-instruction jmp bits and the ALU flags.
// Latency: combinational. Backpressure: none.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // jmp[2]: out<0, jmp[1]: out==0, jmp[0]: out>0
  assign take = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack control unit and A/D/PC register file driving an external combinational ALU.
// Latency: A-instr 2 cycles, C-instr 4 (+1 M read, +1 M write), plus every ack wait cycle.
// Backpressure: each req holds until its ack is sampled; the FSM stalls in place meanwhile.
module hack_ctrl
  import hack_pkg::*;
#(
  parameter int              ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              dmem_rd_req,
  output logic              dmem_wr_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_fn,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc
);

  logic [2:0]        state_q;
  logic [15:0]       a_q;
  logic [15:0]       d_q;
  logic [15:0]       ir_q;
  logic [15:0]       m_q;
  logic [15:0]       r_q;
  logic              take_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              take_w;

  assign pc_inc = pc_q + ADDR_W'(1);

  hack_jump_eval u_jump (
    .jmp  (ir_q[JMP_HI:JMP_LO]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take_w)
  );

  // Requests are gated by rst_n so they fall the instant reset asserts.
  assign imem_req    = rst_n && (state_q == ST_FETCH);
  assign dmem_rd_req = rst_n && (state_q == ST_MEMRD);
  assign dmem_wr_req = rst_n && (state_q == ST_MEMWR);

  assign imem_addr  = pc_q;
  assign dmem_addr  = a_q[ADDR_W-1:0];
  assign dmem_wdata = r_q;
  assign pc         = pc_q;

  assign alu_x  = d_q;
  assign alu_y  = ir_q[BIT_A] ? m_q : a_q;
  assign alu_fn = ir_q[COMP_HI:COMP_LO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      r_q     <= '0;
      take_q  <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!ir_q[BIT_TYPE]) begin
            a_q     <= {1'b0, ir_q[14:0]};
            pc_q    <= pc_inc;
            state_q <= ST_FETCH;
          end else begin
            state_q <= ir_q[BIT_A] ? ST_MEMRD : ST_EXEC;
          end
        end
        ST_MEMRD: begin
          if (dmem_ack) begin
            m_q     <= dmem_rdata;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_q     <= alu_out;
          take_q  <= take_w;
          state_q <= ir_q[BIT_DEST_M] ? ST_MEMWR : ST_WB;
        end
        ST_MEMWR: begin
          if (dmem_ack) state_q <= ST_WB;
        end
        ST_WB: begin
          if (ir_q[BIT_DEST_A]) a_q <= r_q;
          if (ir_q[BIT_DEST_D]) d_q <= r_q;
          // jump target is the A value from before this write-back
          pc_q    <= take_q ? a_q[ADDR_W-1:0] : pc_inc;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_ctrl.sv
// Directed bench for hack_ctrl: instruction table with a reference ALU, plus a mid-write reset sequence.
module tb_hack_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_rd_req;
  logic        dmem_wr_req;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_fn;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  hack_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .dmem_rd_req (dmem_rd_req),
    .dmem_wr_req (dmem_wr_req),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_fn      (alu_fn),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .pc          (pc)
  );

  // Hack ALU: {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] fn);
    logic [15:0] xx, yy, oo;
    xx = fn[5] ? 16'h0000 : x;
    xx = fn[4] ? ~xx : xx;
    yy = fn[3] ? 16'h0000 : y;
    yy = fn[2] ? ~yy : yy;
    oo = fn[1] ? (xx + yy) : (xx & yy);
    return fn[0] ? ~oo : oo;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, alu_fn);
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          im_dly;
    int          dm_dly;
    logic [15:0] rdata;
    logic [14:0] maddr;
    logic [15:0] wdata;
    int          rd_cyc;
    int          wr_cyc;
    int          cyc;
    logic [14:0] pc;
    logic [14:0] a;
    logic [15:0] ex_x;
    logic [15:0] ex_y;
    logic [5:0]  ex_fn;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [15:0] instr, input int im_dly, input int dm_dly,
                              input logic [15:0] rdata, input logic [14:0] maddr,
                              input logic [15:0] wdata, input int rd_cyc, input int wr_cyc,
                              input int cyc, input logic [14:0] pcv, input logic [14:0] av,
                              input logic [15:0] ex_x, input logic [15:0] ex_y,
                              input logic [5:0] ex_fn);
    vec_t v;
    v.instr = instr;   v.im_dly = im_dly; v.dm_dly = dm_dly; v.rdata = rdata;
    v.maddr = maddr;   v.wdata = wdata;   v.rd_cyc = rd_cyc; v.wr_cyc = wr_cyc;
    v.cyc = cyc;       v.pc = pcv;        v.a = av;
    v.ex_x = ex_x;     v.ex_y = ex_y;     v.ex_fn = ex_fn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle until the next FETCH, acting as ROM and RAM.
  task automatic run_vec(input int idx, input vec_t v, input logic [14:0] start_pc);
    int   cyc = 0, icnt = 0, dcnt = 0, wr_n = 0, rd_n = 0;
    bit   left = 0, done = 0, in_dec = 0, rd_acked = 0, exec_seen = 0;
    bit   addr_ok = 1, data_ok = 1, is_c;
    logic [15:0] ex_x = '0, ex_y = '0;
    logic [5:0]  ex_fn = '0;
    string tag;
    tag  = $sformatf("v%0d", idx);
    is_c = v.instr[15];
    chk({tag, " fetch_addr"}, {17'd0, imem_addr}, {17'd0, start_pc});
    while (!done && cyc < 60) begin
      if (left && imem_req) begin
        done = 1;
      end else begin
        cyc++;
        if ((in_dec && is_c && !v.instr[12]) || rd_acked) begin
          exec_seen = 1;
          ex_x  = alu_x;
          ex_y  = alu_y;
          ex_fn = alu_fn;
        end
        if (!imem_req) left = 1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (imem_req) begin
          imem_data = v.instr;
          if (icnt == v.im_dly) begin imem_ack = 1'b1; icnt = 0; end
          else icnt++;
        end else icnt = 0;
        if (dmem_wr_req) begin
          wr_n++;
          if (dmem_addr !== v.maddr) addr_ok = 0;
          if (dmem_wdata !== v.wdata) data_ok = 0;
        end
        if (dmem_rd_req) begin
          rd_n++;
          if (dmem_addr !== v.maddr) addr_ok = 0;
          dmem_rdata = v.rdata;
        end
        if (dmem_rd_req || dmem_wr_req) begin
          if (dcnt == v.dm_dly) begin dmem_ack = 1'b1; dcnt = 0; end
          else dcnt++;
        end else dcnt = 0;
        in_dec   = imem_ack;
        rd_acked = dmem_rd_req && dmem_ack;
        @(posedge clk); #1;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk({tag, " finished"}, {31'd0, done}, 32'd1);
    chk({tag, " cycles"}, cyc, v.cyc);
    chk({tag, " pc"}, {17'd0, pc}, {17'd0, v.pc});
    chk({tag, " a"}, {17'd0, dmem_addr}, {17'd0, v.a});
    chk({tag, " rd_cycles"}, rd_n, v.rd_cyc);
    chk({tag, " wr_cycles"}, wr_n, v.wr_cyc);
    if (rd_n + wr_n > 0) chk({tag, " mem_addr"}, {31'd0, addr_ok}, 32'd1);
    if (wr_n > 0) chk({tag, " wdata"}, {31'd0, data_ok}, 32'd1);
    if (is_c) begin
      chk({tag, " exec_seen"}, {31'd0, exec_seen}, 32'd1);
      chk({tag, " alu_x"}, {16'd0, ex_x}, {16'd0, v.ex_x});
      chk({tag, " alu_y"}, {16'd0, ex_y}, {16'd0, v.ex_y});
      chk({tag, " alu_fn"}, {26'd0, ex_fn}, {26'd0, v.ex_fn});
    end
  endtask

  initial begin
    logic [14:0] cur_pc;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_data  = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;

    //             instr    im dm rdata    maddr   wdata  rd wr cyc pc       a        ex_x     ex_y     ex_fn
    vecs[0]  = mk(16'h1234, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h0001, 15'h1234, 16'h0,    16'h0,    6'b000000);
    vecs[1]  = mk(16'hEC10, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h0002, 15'h1234, 16'h0000, 16'h1234, 6'b110000);
    vecs[2]  = mk(16'h0005, 2, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h0003, 15'h0005, 16'h0,    16'h0,    6'b000000);
    vecs[3]  = mk(16'hEC10, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h0004, 15'h0005, 16'h1234, 16'h0005, 6'b110000);
    vecs[4]  = mk(16'h0064, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h0005, 15'h0064, 16'h0,    16'h0,    6'b000000);
    vecs[5]  = mk(16'hE7C8, 0, 3, 16'h0,   15'd100,16'h6,  0, 4, 8, 15'h0006, 15'h0064, 16'h0005, 16'h0064, 6'b011111);
    vecs[6]  = mk(16'hFC10, 0, 0, 16'hFFFF,15'd100,16'h0,  1, 0, 5, 15'h0007, 15'h0064, 16'h0005, 16'hFFFF, 6'b110000);
    vecs[7]  = mk(16'h0028, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h0008, 15'h0028, 16'h0,    16'h0,    6'b000000);
    vecs[8]  = mk(16'hE301, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h0009, 15'h0028, 16'hFFFF, 16'h0028, 6'b001100);
    vecs[9]  = mk(16'h0064, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h000A, 15'h0064, 16'h0,    16'h0,    6'b000000);
    vecs[10] = mk(16'hFDE8, 0, 0, 16'h0010,15'd100,16'h11, 1, 1, 6, 15'h000B, 15'h0011, 16'hFFFF, 16'h0010, 6'b110111);
    vecs[11] = mk(16'hEEA0, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h000C, 15'h7FFF, 16'hFFFF, 16'h0011, 6'b111010);
    vecs[12] = mk(16'hEA87, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h7FFF, 15'h7FFF, 16'hFFFF, 16'hFFFF, 6'b101010);
    vecs[13] = mk(16'h0028, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h0000, 15'h0028, 16'h0,    16'h0,    6'b000000);
    vecs[14] = mk(16'h7FFD, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h0001, 15'h7FFD, 16'h0,    16'h0,    6'b000000);
    vecs[15] = mk(16'hEA87, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h7FFD, 15'h7FFD, 16'hFFFF, 16'h7FFD, 6'b101010);
    vecs[16] = mk(16'h0028, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 2, 15'h7FFE, 15'h0028, 16'h0,    16'h0,    6'b000000);
    vecs[17] = mk(16'hEA87, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h0028, 15'h0028, 16'hFFFF, 16'h0028, 6'b101010);
    vecs[18] = mk(16'hEA82, 0, 0, 16'h0,   15'd0,  16'h0,  0, 0, 4, 15'h0028, 15'h0028, 16'hFFFF, 16'h0028, 6'b101010);

    repeat (3) @(posedge clk);
    #1;
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst dmem_rd_req", {31'd0, dmem_rd_req}, 32'd0);
    chk("rst dmem_wr_req", {31'd0, dmem_wr_req}, 32'd0);
    chk("rst pc", {17'd0, pc}, 32'd0);
    chk("rst alu_fn", {26'd0, alu_fn}, 32'd0);
    chk("rst alu_x", {16'd0, alu_x}, 32'd0);
    chk("rst alu_y", {16'd0, alu_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst imem_req", {31'd0, imem_req}, 32'd1);

    cur_pc = 15'd0;
    for (int i = 0; i < 19; i++) begin
      run_vec(i, vecs[i], cur_pc);
      cur_pc = vecs[i].pc;
    end

    // M=D+1 at PC=40 with A=40, D=0xFFFF; reset lands while the write is unacknowledged.
    chk("rs fetch", {31'd0, imem_req}, 32'd1);
    imem_data = 16'hE7C8;
    imem_ack  = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rs wr_req", {31'd0, dmem_wr_req}, 32'd1);
    chk("rs wr_addr", {17'd0, dmem_addr}, 32'h28);
    chk("rs wr_data", {16'd0, dmem_wdata}, 32'h0);
    @(posedge clk); #1;
    chk("rs wr_req held", {31'd0, dmem_wr_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs wr_req drop", {31'd0, dmem_wr_req}, 32'd0);
    chk("rs imem_req drop", {31'd0, imem_req}, 32'd0);
    chk("rs pc", {17'd0, pc}, 32'd0);
    chk("rs a_clear", {17'd0, dmem_addr}, 32'd0);
    chk("rs d_clear", {16'd0, alu_x}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 16'hBEEF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("stray wr_req", {31'd0, dmem_wr_req}, 32'd0);
    chk("stray rd_req", {31'd0, dmem_rd_req}, 32'd0);
    chk("stray fetch", {31'd0, imem_req}, 32'd1);
    chk("stray pc", {17'd0, pc}, 32'd0);
    run_vec(19, mk(16'h0007, 0, 0, 16'h0, 15'd0, 16'h0, 0, 0, 2, 15'h0001, 15'h0007,
                   16'h0, 16'h0, 6'b000000), 15'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
